// File: rtl/lcd_refresh_sequencer_if.sv
// LCD pin bundle (HD44780-compatible, 8-bit write-only bus) driven by the refresh sequencer.
interface lcd_refresh_sequencer_if;
  logic       E_out;
  logic       RW_out;
  logic       RS_out;
  logic [7:0] DB_out;

  modport master (output E_out, output RW_out, output RS_out, output DB_out);
  modport slave  (input  E_out, input  RW_out, input  RS_out, input  DB_out);
endinterface

// File: rtl/lcd_refresh_sequencer.sv
// Power-on init of a character LCD, then a continuous refresh of four hex digits
// at a fixed DDRAM address; every byte is a 3-cycle SETUP/STROBE/HOLD write.
module lcd_refresh_sequencer #(
  parameter int unsigned POWERUP_MS    = 20,
  parameter int unsigned CLEAR_WAIT_MS = 2,
  parameter int unsigned REFRESH_MS    = 50,
  parameter logic [6:0]  DDRAM_ADDR    = 7'h00
) (
  input  logic                           clk_1ms,
  input  logic                           reset,
  input  logic [3:0]                     count0,
  input  logic [3:0]                     count1,
  input  logic [3:0]                     count2,
  input  logic [3:0]                     count3,
  lcd_refresh_sequencer_if.master        lcd,
  output logic                           init_done,
  output logic                           frame_done
);

  localparam int unsigned MAXW_A = (POWERUP_MS > CLEAR_WAIT_MS) ? POWERUP_MS : CLEAR_WAIT_MS;
  localparam int unsigned MAXW   = (MAXW_A > REFRESH_MS) ? MAXW_A : REFRESH_MS;
  localparam int unsigned CW     = (MAXW < 2) ? 1 : $clog2(MAXW);

  typedef enum logic [3:0] {
    PWR_WAIT, FS1, FS2, FS3, DISP_ON, CLEAR, CLR_WAIT, ENTRY,
    ADDR, D3, D2, D1, D0, WAIT
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

  // Zero-length waits are bypassed entirely, including the one entered from reset.
  localparam state_t RESET_STATE = (POWERUP_MS == 0)    ? FS1   : PWR_WAIT;
  localparam state_t AFTER_CLEAR = (CLEAR_WAIT_MS == 0) ? ENTRY : CLR_WAIT;
  localparam state_t AFTER_D0    = (REFRESH_MS == 0)    ? ADDR  : WAIT;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0][3:0] snap_q, snap_d;
  logic            init_done_q, init_done_d;
  logic            frame_done_q, frame_done_d;

  logic            is_wait;
  int unsigned     wait_lim;
  state_t          wait_next;
  state_t          byte_next;
  logic [7:0]      byte_val;
  logic            byte_rs;

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      state_q      <= RESET_STATE;
      phase_q      <= PH_SETUP;
      cnt_q        <= '0;
      snap_q       <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Per-state decode: wait length/successor, or byte content/successor.
  always_comb begin
    is_wait   = 1'b0;
    wait_lim  = 0;
    wait_next = state_q;
    byte_next = state_q;
    byte_val  = 8'h00;
    byte_rs   = 1'b0;
    case (state_q)
      PWR_WAIT: begin is_wait = 1'b1; wait_lim = POWERUP_MS;    wait_next = FS1;   end
      CLR_WAIT: begin is_wait = 1'b1; wait_lim = CLEAR_WAIT_MS; wait_next = ENTRY; end
      WAIT:     begin is_wait = 1'b1; wait_lim = REFRESH_MS;    wait_next = ADDR;  end
      FS1:      begin byte_val = 8'h38; byte_next = FS2;         end
      FS2:      begin byte_val = 8'h38; byte_next = FS3;         end
      FS3:      begin byte_val = 8'h38; byte_next = DISP_ON;     end
      DISP_ON:  begin byte_val = 8'h0C; byte_next = CLEAR;       end
      CLEAR:    begin byte_val = 8'h01; byte_next = AFTER_CLEAR; end
      ENTRY:    begin byte_val = 8'h06; byte_next = ADDR;        end
      ADDR:     begin byte_val = {1'b1, DDRAM_ADDR}; byte_next = D3; end
      D3:       begin byte_val = hex_char(snap_q[3]); byte_rs = 1'b1; byte_next = D2; end
      D2:       begin byte_val = hex_char(snap_q[2]); byte_rs = 1'b1; byte_next = D1; end
      D1:       begin byte_val = hex_char(snap_q[1]); byte_rs = 1'b1; byte_next = D0; end
      D0:       begin byte_val = hex_char(snap_q[0]); byte_rs = 1'b1; byte_next = AFTER_D0; end
      default:  begin is_wait = 1'b1; wait_next = PWR_WAIT; end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    snap_d       = snap_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    if (is_wait) begin
      phase_d = PH_SETUP;
      if (32'(cnt_q) + 32'd1 >= wait_lim) begin
        cnt_d   = '0;
        state_d = wait_next;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      case (phase_q)
        PH_SETUP: begin
          phase_d = PH_STROBE;
          if (state_q == ADDR) snap_d = {count3, count2, count1, count0};
        end
        PH_STROBE: phase_d = PH_HOLD;
        default: begin
          phase_d = PH_SETUP;
          state_d = byte_next;
          if (state_q == ENTRY) init_done_d  = 1'b1;
          if (state_q == D0)    frame_done_d = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    lcd.E_out  = 1'b0;
    lcd.RW_out = 1'b0;
    lcd.RS_out = 1'b0;
    lcd.DB_out = 8'h00;
    if (!is_wait) begin
      lcd.E_out  = (phase_q == PH_STROBE);
      lcd.RS_out = byte_rs;
      lcd.DB_out = byte_val;
    end
  end

  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// Scoreboard bench: expected LCD bytes and their strobe spacing are queued with
// the stimulus and compared as each E pulse is observed on the bus.
module tb_lcd_refresh_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] c0, c1, c2, c3;
  logic       init_done, frame_done;

  lcd_refresh_sequencer_if lcd ();

  lcd_refresh_sequencer #(
    .POWERUP_MS   (20),
    .CLEAR_WAIT_MS(2),
    .REFRESH_MS   (50),
    .DDRAM_ADDR   (7'h00)
  ) dut (
    .clk_1ms   (clk),
    .reset     (reset),
    .count0    (c0),
    .count1    (c1),
    .count2    (c2),
    .count3    (c3),
    .lcd       (lcd.master),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         gap;
  } exp_t;

  exp_t sbq[$];
  int   errs = 0;
  int   nchk = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    if (obs !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [7:0] ascii_hex(input logic [3:0] d);
    int v;
    v = int'(d);
    if (v <= 9) return 8'(48 + v);
    return 8'(65 + (v - 10));
  endfunction

  task automatic push_byte(input logic rs, input logic [7:0] db, input int gap);
    exp_t e;
    e.rs = rs; e.db = db; e.gap = gap;
    sbq.push_back(e);
  endtask

  task automatic push_init();
    push_byte(1'b0, 8'h38, 22);  // 20 idle cycles after release, then SETUP, STROBE
    push_byte(1'b0, 8'h38, 3);
    push_byte(1'b0, 8'h38, 3);
    push_byte(1'b0, 8'h0C, 3);
    push_byte(1'b0, 8'h01, 3);
    push_byte(1'b0, 8'h06, 5);
  endtask

  task automatic push_frame(input int addr_gap, input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
    push_byte(1'b0, 8'h80, addr_gap);
    push_byte(1'b1, ascii_hex(d3), 3);
    push_byte(1'b1, ascii_hex(d2), 3);
    push_byte(1'b1, ascii_hex(d1), 3);
    push_byte(1'b1, ascii_hex(d0), 3);
  endtask

  // Bus monitor, sampled on the falling edge.
  int         since = 0;
  int         npulse = 0;
  int         data_run = 0;
  logic       prev_e = 1'b0, prev_rs = 1'b0;
  logic [7:0] prev_db = 8'h00;
  logic       hold_pend = 1'b0, entry_seen = 1'b0, d0_seen = 1'b0;
  logic       p_rs;
  logic [7:0] p_db;

  always @(negedge clk) begin
    if (!reset) begin
      since = 0; hold_pend = 1'b0; entry_seen = 1'b0; d0_seen = 1'b0;
      data_run = 0; prev_e = 1'b0;
    end else begin
      exp_t e;
      since++;
      check("rw_zero", 32'(lcd.RW_out), 32'd0);
      if (hold_pend) begin
        check("e_width", 32'(lcd.E_out), 32'd0);
        check("hold_rs", 32'(lcd.RS_out), 32'(p_rs));
        check("hold_db", 32'(lcd.DB_out), 32'(p_db));
        hold_pend = 1'b0;
      end
      if (entry_seen && since == 1) check("init_done_hold", 32'(init_done), 32'd0);
      if (entry_seen && since == 2) begin
        check("init_done_rise", 32'(init_done), 32'd1);
        entry_seen = 1'b0;
      end
      if (d0_seen && since == 1) check("frame_done_hold", 32'(frame_done), 32'd0);
      if (d0_seen && since == 2) check("frame_done_pulse", 32'(frame_done), 32'd1);
      if (d0_seen && since == 3) begin
        check("frame_done_fall", 32'(frame_done), 32'd0);
        d0_seen = 1'b0;
      end
      if (lcd.E_out) begin
        npulse++;
        check("setup_e", 32'(prev_e), 32'd0);
        check("setup_rs", 32'(prev_rs), 32'(lcd.RS_out));
        check("setup_db", 32'(prev_db), 32'(lcd.DB_out));
        if (sbq.size() == 0) begin
          check("sb_extra_byte", {23'd0, lcd.RS_out, lcd.DB_out}, 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          check("byte_rs", 32'(lcd.RS_out), 32'(e.rs));
          check("byte_db", 32'(lcd.DB_out), 32'(e.db));
          check("byte_gap", 32'(since), 32'(e.gap));
        end
        if (!lcd.RS_out && lcd.DB_out == 8'h06) entry_seen = 1'b1;
        data_run = lcd.RS_out ? data_run + 1 : 0;
        if (data_run == 4) d0_seen = 1'b1;
        p_rs = lcd.RS_out;
        p_db = lcd.DB_out;
        hold_pend = 1'b1;
        since = 0;
      end
      prev_e  = lcd.E_out;
      prev_rs = lcd.RS_out;
      prev_db = lcd.DB_out;
    end
  end

  // Returns just after the falling edge on which the target pulse count is reached.
  task automatic wait_pulses(input string tag, input int target, input int budget);
    int b;
    b = budget;
    while (npulse < target && b > 0) begin
      @(negedge clk);
      #1;
      b--;
    end
    if (npulse < target) check({"timeout_", tag}, 32'(npulse), 32'(target));
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_e"},  32'(lcd.E_out), 32'd0);
    check({tag, "_rw"}, 32'(lcd.RW_out), 32'd0);
    check({tag, "_rs"}, 32'(lcd.RS_out), 32'd0);
    check({tag, "_db"}, 32'(lcd.DB_out), 32'd0);
    check({tag, "_init_done"},  32'(init_done), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    c3 = 4'h1; c2 = 4'h2; c1 = 4'h3; c0 = 4'h4;
    #1;
    check_idle_reset("reset0");
    push_init();
    push_frame(3, 4'h1, 4'h2, 4'h3, 4'h4);
    @(posedge clk); #2 reset = 1'b1;

    wait_pulses("frame1", 11, 300);
    c3 = 4'hA; c2 = 4'hF; c1 = 4'h9; c0 = 4'h0;
    push_frame(53, 4'hA, 4'hF, 4'h9, 4'h0);

    wait_pulses("frame2", 16, 200);
    c3 = 4'h1; c2 = 4'h2; c1 = 4'h3; c0 = 4'h4;
    push_frame(53, 4'h1, 4'h2, 4'h3, 4'h4);

    // Frame 3 D2 strobe: a late count0 change must wait for the next frame.
    wait_pulses("frame3_d2", 19, 200);
    c0 = 4'h7;
    push_frame(53, 4'h1, 4'h2, 4'h3, 4'h7);

    wait_pulses("frame4", 26, 200);
    push_byte(1'b0, 8'h80, 53);
    push_byte(1'b1, 8'h31, 3);

    // Reset asserted inside the STROBE of the first data byte of frame 5.
    wait_pulses("frame5_d3", 28, 200);
    check("pre_reset_e", 32'(lcd.E_out), 32'd1);
    reset = 1'b0;
    #1;
    check_idle_reset("midreset");
    repeat (3) @(posedge clk);
    push_init();
    push_frame(3, 4'h1, 4'h2, 4'h3, 4'h7);
    for (int unsigned f = 0; f < 9; f++) push_frame(53, 4'h1, 4'h2, 4'h3, 4'h7);
    @(posedge clk); #2 reset = 1'b1;

    wait_pulses("long_run", 28 + 6 + 50, 1500);
    repeat (4) @(negedge clk);
    #1;
    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/lcd_refresh_sequencer.md
Name: lcd_refresh_sequencer

Overview:
- Master sequencer for the character LCD bus (HD44780-compatible, 8-bit interface).
- After reset it runs the power-on initialisation sequence.
- It then continuously refreshes four hex/BCD digits taken from count3..count0 at a fixed DDRAM address.
- It owns E/RW/RS/DB timing, so the display path needs no other LCD logic. It sits between the counter datapath and the LCD pins.

Parameters:
- POWERUP_MS, 20, idle cycles of clk_1ms after reset before the first command.
- CLEAR_WAIT_MS, 2, extra idle cycles after the Clear Display command.
- REFRESH_MS, 50, idle cycles between end of one frame and start of the next.
- DDRAM_ADDR, 7'h00, display address of the first (leftmost) digit.

Ports:
- clk_1ms, input, 1, 1 kHz system clock; all logic on the rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
- count0, input, 4, least significant digit, shown rightmost.
- count1, input, 4, digit 1.
- count2, input, 4, digit 2.
- count3, input, 4, most significant digit, shown leftmost.
- E_out, output, 1, LCD enable strobe.
- RW_out, output, 1, LCD read/write; tied 0 (write-only).
- RS_out, output, 1, register select (0 = command, 1 = data).
- DB_out, output, 8, LCD data bus.
- init_done, output, 1, high once the initialisation sequence completes; stays high until reset.
- frame_done, output, 1, one-cycle pulse after the last digit of each frame is written.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: E_out=0, RW_out=0, RS_out=0, DB_out=8'h00, init_done=0, frame_done=0.
  - FSM goes to PWR_WAIT; cycle counter cleared; digit snapshot cleared.
  - Reset mid-transfer drops E_out immediately and restarts the full initialisation.
- Byte write: every byte is exactly 3 cycles.
  - SETUP: RS_out/DB_out driven, E_out=0.
  - STROBE: E_out=1, RS_out/DB_out held.
  - HOLD: E_out=0, RS_out/DB_out held.
  - RS_out/DB_out never change while E_out=1. RW_out is always 0.
- Init sequence:
  - PWR_WAIT: POWERUP_MS cycles with the bus idle (E=0, RS=0, DB=00).
  - Then commands with RS=0, in order: 0x38, 0x38, 0x38 (function set), 0x0C (display on, cursor off), 0x01 (clear).
  - CLR_WAIT: CLEAR_WAIT_MS idle cycles.
  - Then 0x06 (entry mode, increment).
  - init_done rises in the cycle after the 0x06 HOLD cycle.
- Refresh frame:
  - ADDR command: RS=0, DB=8'h80|DDRAM_ADDR.
  - Snapshot: count3..count0 are captured into internal registers in the ADDR SETUP cycle. The frame displays that snapshot; input changes mid-frame have no effect until the next frame.
  - Four data bytes follow with RS=1, in the order snapshot3, 2, 1, 0.
  - frame_done=1 for exactly the cycle after the last data HOLD cycle.
  - WAIT: REFRESH_MS idle cycles, then the next frame begins with ADDR SETUP.
  - Frame length: 15 write cycles + REFRESH_MS idle cycles.
- Digit encoding (combinational from snapshot):
  - d = 0..9 maps to 8'h30+d ('0'..'9').
  - d = 10..15 maps to 8'h41+(d-10) ('A'..'F').
- Idle bus: in wait states E=0, RS=0, DB=8'h00.
- FSM states, transitions unconditional on counter expiry:
  - PWR_WAIT → FS1 → FS2 → FS3 → DISP_ON → CLEAR → CLR_WAIT → ENTRY
  - → ADDR → D3 → D2 → D1 → D0 → WAIT → ADDR …
  - Each command/data state contains the 3-phase sub-sequence.
- Counters: wide enough for max(POWERUP_MS, CLEAR_WAIT_MS, REFRESH_MS). A parameter value of 0 skips that wait state, so no zero-length hang occurs.
- No input handshake: counts are free-running levels and are sampled only at the snapshot point.

Test Plan:
1. Reset at t=0, release, defaults. Required response:
   - Bus idle for exactly 20 cycles.
   - E_out pulses carry 0x38, 0x38, 0x38, 0x0C, 0x01 with RS=0.
   - 2 idle cycles, then 0x06.
   - init_done rises 1 cycle after the 0x06 HOLD.
2. Counts 3,2,1,0 = 1,2,3,4 after init. Required response:
   - ADDR byte 0x80.
   - Data bytes 0x31, 0x32, 0x33, 0x34 with RS=1.
   - frame_done single-cycle pulse, then 50 idle cycles before the next 0x80.
3. Counts = A, F, 9, 0. Required response: data 0x41, 0x46, 0x39, 0x30.
4. Change count0 from 4 to 7 during the D2 byte. Required response:
   - Current frame still sends 0x34.
   - Next frame sends 0x37.
5. Assert reset (0) during the STROBE cycle of the first data byte. Required response:
   - E_out falls in the same cycle (asynchronous); DB=00; init_done=0.
   - After release, the full init sequence repeats from PWR_WAIT.
6. Check every E_out pulse in a 1000-cycle run. Required response:
   - Each pulse is exactly 1 cycle wide.
   - RS/DB are stable from SETUP through HOLD.
   - RW_out = 0 throughout.
